// File: rtl/cpu_pkg.sv
// Shared CPU definitions: canonical NOP, register-field positions and fetch FSM states.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0, x0, 0
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble (flush) beats load; with neither asserted the contents hold.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              bubble,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic [31:0]       next_instr,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic              valid
);

    // Register update: reset, then bubble insertion, then load of a fetched instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= next_pc;
            instr <= next_instr;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, the single-outstanding imem handshake,
// branch redirect/drain and a one-entry hold buffer used while the pipeline stalls.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              PCWrite_i,
    input  logic              Stall_i,
    input  logic              Flush_i,
    input  logic [ADDR_W-1:0] BranchTarget_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [ADDR_W-1:0] IFID_pc_o,
    output logic [31:0]       IFID_instr_o,
    output logic              IFID_valid_o,
    output logic [4:0]        RS1addr_o,
    output logic [4:0]        RS2addr_o
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              req;
    logic [31:0]       hold_instr;
    logic              advance;
    logic              ifid_load;
    logic              ifid_bubble;
    logic [31:0]       ifid_instr;

    assign advance     = PCWrite_i & ~Stall_i;
    assign imem_req_o  = req;
    assign imem_addr_o = pc;

    // IF/ID control: flush bubbles, an accepted instruction loads, an empty unstalled slot bubbles.
    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_instr  = imem_rdata_i;
        case (state)
            ST_FETCH: begin
                if (Flush_i) begin
                    ifid_bubble = 1'b1;
                end else if (imem_rvalid_i) begin
                    ifid_load = advance;
                end else if (!Stall_i) begin
                    ifid_bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (Flush_i) begin
                    ifid_bubble = 1'b1;
                end else if (advance) begin
                    ifid_load  = 1'b1;
                    ifid_instr = hold_instr;
                end
            end
            ST_DRAIN: ifid_bubble = Flush_i | ~Stall_i;
            default: ;
        endcase
    end

    // Fetch FSM with registered request; DRAIN swallows the response of a request killed by a flush.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            req        <= 1'b0;
            hold_instr <= NOP_INSTR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state <= ST_FETCH;
                        pc    <= RESET_PC;
                        req   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (Flush_i) begin
                        pc <= BranchTarget_i;
                        if (!imem_rvalid_i) begin
                            state <= ST_DRAIN;
                            req   <= 1'b0;
                        end
                    end else if (imem_rvalid_i) begin
                        if (advance) begin
                            pc <= pc + ADDR_W'(4);
                        end else begin
                            hold_instr <= imem_rdata_i;
                            state      <= ST_HOLD;
                            req        <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (Flush_i) begin
                        pc         <= BranchTarget_i;
                        hold_instr <= NOP_INSTR;
                        state      <= ST_FETCH;
                        req        <= 1'b1;
                    end else if (advance) begin
                        pc    <= pc + ADDR_W'(4);
                        state <= ST_FETCH;
                        req   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // A redirect here only retargets the PC; the killed response must still be absorbed.
                    if (Flush_i) begin
                        pc <= BranchTarget_i;
                    end
                    if (imem_rvalid_i) begin
                        state <= ST_FETCH;
                        req   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .ADDR_W(ADDR_W)
    ) u_if_id_reg (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .load       (ifid_load),
        .bubble     (ifid_bubble),
        .next_pc    (pc),
        .next_instr (ifid_instr),
        .pc         (IFID_pc_o),
        .instr      (IFID_instr_o),
        .valid      (IFID_valid_o)
    );

    assign RS1addr_o = IFID_instr_o[RS1_LSB +: REG_ADDR_W];
    assign RS2addr_o = IFID_instr_o[RS2_LSB +: REG_ADDR_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model, program-order scoreboard, directed and random phases.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        PCWrite_i = 1'b1;
    logic        Stall_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic [31:0] BranchTarget_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] IFID_pc_o;
    logic [31:0] IFID_instr_o;
    logic        IFID_valid_o;
    logic [4:0]  RS1addr_o;
    logic [4:0]  RS2addr_o;

    fetch_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .PCWrite_i      (PCWrite_i),
        .Stall_i        (Stall_i),
        .Flush_i        (Flush_i),
        .BranchTarget_i (BranchTarget_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .IFID_pc_o      (IFID_pc_o),
        .IFID_instr_o   (IFID_instr_o),
        .IFID_valid_o   (IFID_valid_o),
        .RS1addr_o      (RS1addr_o),
        .RS2addr_o      (RS2addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    logic [31:0] next_pc = '0;
    bit          stream_on = 1'b0;
    bit          mon_en = 1'b0;

    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          lat_mode = 1;
    logic [31:0] acc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] s;
        s = a * 32'h9E37_79B1;
        return s ^ {a[7:0], a[31:24], 16'h5A3C};
    endfunction

    // Expected program order: consecutive words from the current redirect point.
    task automatic topup();
        exp_t e;
        while (exp_q.size() < 16) begin
            e.pc    = next_pc;
            e.instr = mem_word(next_pc);
            exp_q.push_back(e);
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic redirect(input logic [31:0] t);
        exp_q.delete();
        next_pc   = t;
        stream_on = 1'b1;
        topup();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        if (stream_on) topup();
    endtask

    task automatic wait_mem(input int cnt_val, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mem_busy && mem_cnt == cnt_val) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // Memory: accepts one request at a time, answers with a one-cycle rvalid pulse after the latency.
    always @(negedge clk) begin
        #2;
        imem_rvalid_i = 1'b0;
        if (mem_busy) begin
            if (imem_req_o) check("addr_stable", imem_addr_o, mem_addr);
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(mem_addr);
                mem_busy      = 1'b0;
            end
        end else if (imem_req_o) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr_o;
            acc_q.push_back(imem_addr_o);
            mem_cnt = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
        end
    end

    // Monitor: a valid IF/ID after an unstalled edge is a newly delivered instruction.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (IFID_valid_o && !Stall_i) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("id_unexpected_entry");
                end else begin
                    e = exp_q.pop_front();
                    check("id_pc", IFID_pc_o, e.pc);
                    check("id_instr", IFID_instr_o, e.instr);
                    check("id_rs1", {27'd0, RS1addr_o}, {27'd0, e.instr[19:15]});
                    check("id_rs2", {27'd0, RS2addr_o}, {27'd0, e.instr[24:20]});
                end
            end else if (!IFID_valid_o) begin
                check("bubble_instr", IFID_instr_o, NOP);
                check("bubble_rs1", {27'd0, RS1addr_o}, 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;

        // Reset values
        tick();
        tick();
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_valid", {31'd0, IFID_valid_o}, 32'd0);
        check("rst_instr", IFID_instr_o, NOP);
        check("rst_ifid_pc", IFID_pc_o, 32'd0);
        check("rst_addr", imem_addr_o, 32'd0);
        check("rst_rs2", {27'd0, RS2addr_o}, 32'd0);
        rst_i  = 1'b1;
        mon_en = 1'b1;
        tick();
        check("idle_no_req", {31'd0, imem_req_o}, 32'd0);

        // Start with 1-cycle memory: request stream 0x0, 0x4, 0x8
        lat_mode = 1;
        acc_q.delete();
        redirect(32'h0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (8) tick();
        if (acc_q.size() >= 3) begin
            check("start_addr0", acc_q[0], 32'h0);
            check("start_addr1", acc_q[1], 32'h4);
            check("start_addr2", acc_q[2], 32'h8);
        end else timeout_fail("start_addr_seq");

        // Stall as a response arrives: hold buffer, IF/ID frozen, no request
        wait_mem(1, ok);
        if (!ok) timeout_fail("stall_wait");
        Stall_i   = 1'b1;
        PCWrite_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_req", {31'd0, imem_req_o}, 32'd0);
            check("hold_valid", {31'd0, IFID_valid_o}, 32'd0);
            check("hold_instr", IFID_instr_o, NOP);
        end
        Stall_i   = 1'b0;
        PCWrite_i = 1'b1;
        tick();
        check("release_valid", {31'd0, IFID_valid_o}, 32'd1);
        repeat (4) tick();

        // Flush while a slow request is outstanding: drain, then fetch the target
        lat_mode = 3;
        wait_mem(2, ok);
        if (!ok) timeout_fail("flush_wait");
        n = acc_q.size();
        Flush_i        = 1'b1;
        BranchTarget_i = 32'h100;
        redirect(32'h100);
        tick();
        Flush_i = 1'b0;
        check("drain_req", {31'd0, imem_req_o}, 32'd0);
        check("drain_valid", {31'd0, IFID_valid_o}, 32'd0);
        for (int i = 0; i < 20 && acc_q.size() <= n; i++) tick();
        if (acc_q.size() > n) check("drain_next_addr", acc_q[n], 32'h100);
        else timeout_fail("drain_next_addr");
        repeat (8) tick();

        // Flush and stall together: flush wins
        lat_mode = 1;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            ok = IFID_valid_o;
        end
        if (!ok) timeout_fail("flush_stall_wait");
        Flush_i        = 1'b1;
        Stall_i        = 1'b1;
        PCWrite_i      = 1'b0;
        BranchTarget_i = 32'h200;
        redirect(32'h200);
        tick();
        check("fs_valid", {31'd0, IFID_valid_o}, 32'd0);
        check("fs_instr", IFID_instr_o, NOP);
        check("fs_pc", imem_addr_o, 32'h200);
        Flush_i   = 1'b0;
        Stall_i   = 1'b0;
        PCWrite_i = 1'b1;
        repeat (8) tick();

        // PC wrap at the top of the address space
        lat_mode = 0;
        n = acc_q.size();
        Flush_i        = 1'b1;
        BranchTarget_i = 32'hFFFF_FFFC;
        redirect(32'hFFFF_FFFC);
        tick();
        Flush_i = 1'b0;
        repeat (20) tick();
        if (acc_q.size() >= n + 2) begin
            check("wrap_addr_top", acc_q[n], 32'hFFFF_FFFC);
            check("wrap_addr_zero", acc_q[n + 1], 32'h0);
        end else timeout_fail("wrap_addr_seq");

        // Reset mid-request: late response ignored, idle until start
        lat_mode = 3;
        wait_mem(2, ok);
        if (!ok) timeout_fail("rst_mid_wait");
        rst_i     = 1'b0;
        stream_on = 1'b0;
        exp_q.delete();
        tick();
        rst_i = 1'b1;
        for (int i = 0; i < 10 && mem_busy; i++) tick();
        if (mem_busy) timeout_fail("rst_mid_resp");
        repeat (2) tick();
        check("rstmid_req", {31'd0, imem_req_o}, 32'd0);
        check("rstmid_valid", {31'd0, IFID_valid_o}, 32'd0);
        check("rstmid_instr", IFID_instr_o, NOP);
        check("rstmid_ifid_pc", IFID_pc_o, 32'd0);
        check("rstmid_addr", imem_addr_o, 32'd0);

        // Random phase
        lat_mode = 0;
        redirect(32'h0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            Stall_i   = ($urandom_range(0, 3) == 0);
            PCWrite_i = ~Stall_i;
            Flush_i   = ($urandom_range(0, 19) == 0);
            if (Flush_i) begin
                BranchTarget_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
                redirect(BranchTarget_i);
            end
            tick();
        end
        Stall_i   = 1'b0;
        PCWrite_i = 1'b1;
        Flush_i   = 1'b0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
